// File: rtl/hazard_forward_unit.sv
// Load-use stall and EX operand-forward select generation for the 5-stage pipeline.
// Optional stall counter enabled by defining HFU_STALL_COUNT_EN.
module hazard_forward_unit #(
    parameter int               REG_W    = 5,
    parameter logic [REG_W-1:0] ZERO_REG = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [15:0]      stall_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } ex_slot_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
    } mem_slot_t;

    // The WB slot never drives a select (write-before-read regfile),
    // so only EX and MEM occupants are kept.
    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q, mem_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic accept;

    always_comb begin
        ex_rs  = ex_q.valid && ex_q.reg_write &&
                 (ex_q.dest == id_rs) && (id_rs != ZERO_REG);
        ex_rt  = ex_q.valid && ex_q.reg_write &&
                 (ex_q.dest == id_rt) && (id_rt != ZERO_REG);
        mem_rs = mem_q.valid && mem_q.reg_write &&
                 (mem_q.dest == id_rs) && (id_rs != ZERO_REG);
        mem_rt = mem_q.valid && mem_q.reg_write &&
                 (mem_q.dest == id_rt) && (id_rt != ZERO_REG);
    end

    assign stall = id_valid && !flush && ex_q.mem_read &&
                   (ex_rs || (id_uses_rt && ex_rt));
    assign accept = id_valid && !flush && !stall;

    always_comb begin
        ex_d            = '0;
        mem_d.valid     = ex_q.valid;
        mem_d.dest      = ex_q.dest;
        mem_d.reg_write = ex_q.reg_write;
        fwd_a_d         = 2'b00;
        fwd_b_d         = 2'b00;
        if (accept) begin
            ex_d.valid     = 1'b1;
            ex_d.dest      = id_dest;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            if (ex_rs)
                fwd_a_d = 2'b10;
            else if (mem_rs)
                fwd_a_d = 2'b01;
            if (id_uses_rt) begin
                if (ex_rt)
                    fwd_b_d = 2'b10;
                else if (mem_rt)
                    fwd_b_d = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

`ifdef HFU_STALL_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 16'h0000;
        else
            cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: stall checked before each
// edge, forward selects checked from a scoreboard after the edge.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rt, id_reg_write, id_mem_read, flush;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_count;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        string      name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // One ID cycle: drive, check comb stall, push expected selects,
    // clock, pop and compare registered selects.
    task automatic issue(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ut,
                         input logic [4:0] dest, input logic rw,
                         input logic mr, input logic fl,
                         input logic e_stall, input logic [1:0] e_a,
                         input logic [1:0] e_b, input string name);
        exp_t e, got;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
        nchecks++;
        if (stall !== e_stall) begin
            nerr++;
            $display("FAIL %s stall: got %b, required %b", name, stall, e_stall);
        end
        e.a = e_a; e.b = e_b; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        nchecks++;
        if (fwd_a !== got.a || fwd_b !== got.b) begin
            nerr++;
            $display("FAIL %s fwd: got a=%b b=%b, required a=%b b=%b",
                     got.name, fwd_a, fwd_b, got.a, got.b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "idle");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_dest = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        #3;
        nchecks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 ||
            stall_count !== 16'h0) begin
            nerr++;
            $display("FAIL reset_init: got stall=%b a=%b b=%b cnt=%h, required 0 00 00 0000",
                     stall, fwd_a, fwd_b, stall_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1, 1, 0, 0, 2, 1, 0, 0, 0, 2'b00, 2'b00, "rst_add_r2");
        issue(1, 2, 0, 0, 5, 1, 1, 0, 0, 2'b10, 2'b00, "rst_lw_r5");
        id_valid = 1; id_rs = 5; id_rt = 0; id_uses_rt = 0;
        id_dest = 10; id_reg_write = 1; id_mem_read = 0; flush = 0;
        #1;
        nchecks++;
        if (stall !== 1'b1) begin
            nerr++;
            $display("FAIL rst_pre_stall: got %b, required 1", stall);
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            nerr++;
            $display("FAIL rst_mid_stall: got stall=%b a=%b b=%b, required 0 00 00",
                     stall, fwd_a, fwd_b);
        end
        id_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1, 5, 2, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, "rst_empty1");
        issue(1, 5, 2, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, "rst_empty2");
        issue(1, 2, 5, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, "rst_empty3");
    endtask

    task automatic test_alu_chain;
        idle(2);
        issue(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "alu_add_r3");
        issue(1, 3, 4, 1, 6, 1, 0, 0, 0, 2'b10, 2'b00, "alu_sub_ex");
        issue(1, 3, 0, 0, 7, 1, 0, 0, 0, 2'b01, 2'b00, "alu_third_mem");
        issue(1, 8, 6, 1, 9, 1, 0, 0, 0, 2'b00, 2'b01, "alu_rt_mem");
    endtask

    task automatic test_load_use;
        idle(2);
        issue(1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "lu_lw_r5");
        issue(1, 5, 9, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "lu_stall");
        issue(1, 5, 9, 1, 10, 1, 0, 0, 0, 2'b01, 2'b00, "lu_resume");
        idle(2);
        issue(1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "lu_lw_r5b");
        issue(1, 9, 5, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "lu_stall_rt");
        issue(1, 9, 5, 1, 10, 1, 0, 0, 0, 2'b00, 2'b01, "lu_resume_rt");
        idle(2);
        issue(1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "lu_lw_r5c");
        issue(1, 9, 5, 0, 10, 1, 0, 0, 0, 2'b00, 2'b00, "lu_rt_unused");
    endtask

    task automatic test_filters;
        idle(2);
        issue(1, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, "zf_lw_r0");
        issue(1, 0, 0, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, "zf_read_r0");
        issue(1, 1, 2, 1, 11, 0, 0, 0, 0, 2'b00, 2'b00, "zf_nowrite_r11");
        issue(1, 11, 11, 1, 14, 1, 0, 0, 0, 2'b00, 2'b00, "zf_read_r11");
        issue(1, 1, 2, 1, 13, 1, 0, 0, 0, 2'b00, 2'b00, "zf_write_r13");
        issue(1, 1, 13, 0, 15, 1, 0, 0, 0, 2'b00, 2'b00, "zf_rt_unused");
    endtask

    task automatic test_priority_flush;
        idle(2);
        issue(1, 1, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, "pr_w7a");
        issue(1, 0, 0, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, "pr_w7b");
        issue(1, 7, 7, 1, 8, 1, 0, 0, 0, 2'b10, 2'b10, "pr_both");
        idle(2);
        issue(1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "fl_lw_r5");
        issue(1, 5, 0, 0, 5, 1, 0, 1, 0, 2'b00, 2'b00, "fl_flushed");
        issue(1, 5, 0, 0, 16, 1, 0, 0, 0, 2'b01, 2'b00, "fl_after");
    endtask

    task automatic test_stall_count;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, "sc_lw");
            issue(1, 5, 0, 0, 6, 1, 0, 0, 1, 2'b00, 2'b00, "sc_stall");
            issue(1, 5, 0, 0, 6, 1, 0, 0, 0, 2'b01, 2'b00, "sc_resume");
        end
        nchecks++;
`ifdef HFU_STALL_COUNT_EN
        if (stall_count !== 16'd3) begin
            nerr++;
            $display("FAIL stall_count: got %0d, required 3", stall_count);
        end
`else
        if (stall_count !== 16'd0) begin
            nerr++;
            $display("FAIL stall_count_off: got %0d, required 0", stall_count);
        end
`endif
    endtask

    task automatic test_back_to_back;
        idle(2);
        issue(1, 1, 0, 0, 20, 1, 0, 0, 0, 2'b00, 2'b00, "bb_p1");
        issue(1, 20, 0, 0, 21, 1, 0, 0, 0, 2'b10, 2'b00, "bb_p2");
        issue(1, 20, 21, 1, 22, 1, 0, 0, 0, 2'b01, 2'b10, "bb_p3");
        issue(1, 22, 21, 1, 23, 1, 0, 0, 0, 2'b10, 2'b01, "bb_p4");
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_filters();
        test_priority_flush();
        test_back_to_back();
        test_stall_count();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
